// File: rtl/ysyx_22051468_decode_stage.sv
// ysyx_22051468_decode_stage: registered RV32/RV64 decode stage with valid/ready handshakes,
// a 2-entry skid buffer and serialization after EBREAK/illegal instructions.
module ysyx_22051468_decode_stage #(
   parameter int WIDTH = 64,
   parameter int EN_M  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [WIDTH-1:0] in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic [WIDTH-1:0] out_pc,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic [WIDTH-1:0] out_imm,
   output logic             out_rs1_need,
   output logic             out_rs2_need,
   output logic             out_rd_need,
   output logic [3:0]       out_class,
   output logic [2:0]       out_funct3,
   output logic             out_is_w,
   output logic             out_is_muldiv
);
   localparam logic [3:0] C_R = 4'd0, C_I = 4'd1, C_LD = 4'd2, C_ST = 4'd3, C_BR = 4'd4, C_JAL = 4'd5,
                          C_JALR = 4'd6, C_LUI = 4'd7, C_AUI = 4'd8, C_EBRK = 4'd9, C_ILL = 4'd15;
   localparam bit RV64 = (WIDTH == 64);
   localparam bit HAS_M = (EN_M != 0);
   typedef enum logic {RUN, DRAIN} state_t;
   typedef struct packed {
      logic [31:0]      inst;
      logic [WIDTH-1:0] pc;
      logic [4:0]       rs1, rs2, rd;
      logic [WIDTH-1:0] imm;
      logic             rs1_need, rs2_need, rd_need;
      logic [3:0]       cls;
      logic [2:0]       funct3;
      logic             is_w, is_muldiv;
   } bundle_t;
   bundle_t dec, out_q, out_d, skid_q, skid_d;
   state_t state_q, state_d;
   logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_fire, out_fire, legal_r, ill;
   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic [3:0] cls;
   logic [WIDTH-1:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j;
   assign opc = in_inst[6:0];
   assign f7 = in_inst[31:25];
   assign f3 = in_inst[14:12];
   assign imm_i = {{(WIDTH-11){in_inst[31]}}, in_inst[30:20]};
   assign imm_s = {{(WIDTH-11){in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
   assign imm_b = {{(WIDTH-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign imm_u = {{(WIDTH-31){in_inst[31]}}, in_inst[30:12], 12'b0};
   assign imm_j = {{(WIDTH-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
   always_comb begin
      legal_r = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                (f7 == 7'b0000001 && HAS_M);
      cls = C_ILL;
      imm = '0;
      case (opc)
         7'b0110011: cls = legal_r ? C_R : C_ILL;
         7'b0111011: cls = (legal_r && RV64) ? C_R : C_ILL;
         7'b0010011: begin
            cls = (!RV64 && f3[1:0] == 2'b01 && in_inst[25]) ? C_ILL : C_I;
            imm = imm_i;
         end
         7'b0011011: begin cls = RV64 ? C_I : C_ILL; imm = imm_i; end
         7'b0000011: begin cls = C_LD; imm = imm_i; end
         7'b0100011: begin cls = C_ST; imm = imm_s; end
         7'b1100011: begin cls = C_BR; imm = imm_b; end
         7'b1101111: begin cls = C_JAL; imm = imm_j; end
         7'b1100111: begin cls = C_JALR; imm = imm_i; end
         7'b0110111: begin cls = C_LUI; imm = imm_u; end
         7'b0010111: begin cls = C_AUI; imm = imm_u; end
         7'b1110011: cls = (in_inst == 32'h0010_0073) ? C_EBRK : C_ILL;
         default: cls = C_ILL;
      endcase
      ill = (cls == C_ILL);
      dec = '0;
      dec.inst = in_inst;
      dec.pc = in_pc;
      dec.cls = cls;
      dec.funct3 = f3;
      dec.rs1 = ill ? 5'd0 : in_inst[19:15];
      dec.rs2 = ill ? 5'd0 : in_inst[24:20];
      dec.rd = ill ? 5'd0 : in_inst[11:7];
      dec.imm = ill ? '0 : imm;
      dec.rs1_need = cls inside {C_R, C_I, C_LD, C_ST, C_BR, C_JALR};
      dec.rs2_need = cls inside {C_R, C_ST, C_BR};
      dec.rd_need = cls inside {C_R, C_I, C_LD, C_JAL, C_JALR, C_LUI, C_AUI};
      dec.is_w = !ill && (opc == 7'b0111011 || opc == 7'b0011011);
      dec.is_muldiv = !ill && (opc == 7'b0110011 || opc == 7'b0111011) && f7 == 7'b0000001;
   end
   assign in_ready = !skid_valid_q && state_q == RUN && !rst;
   assign in_fire = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;
   // The output register refills from the skid first so ordering stays FIFO.
   always_comb begin
      out_d = out_q;
      out_valid_d = out_valid_q;
      skid_d = skid_q;
      skid_valid_d = skid_valid_q;
      state_d = state_q;
      if (flush) begin
         out_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         state_d = RUN;
      end else begin
         if (in_fire && (dec.cls == C_EBRK || dec.cls == C_ILL)) state_d = DRAIN;
         if (out_fire || !out_valid_q) begin
            out_valid_d = skid_valid_q || in_fire;
            out_d = skid_valid_q ? skid_q : (in_fire ? dec : out_q);
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            skid_d = dec;
            skid_valid_d = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
         skid_q <= '0;
         out_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         state_q <= RUN;
      end else begin
         out_q <= out_d;
         skid_q <= skid_d;
         out_valid_q <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         state_q <= state_d;
      end
   end
   assign out_valid = out_valid_q;
   assign out_inst = out_q.inst;
   assign out_pc = out_q.pc;
   assign out_rs1 = out_q.rs1;
   assign out_rs2 = out_q.rs2;
   assign out_rd = out_q.rd;
   assign out_imm = out_q.imm;
   assign out_rs1_need = out_q.rs1_need;
   assign out_rs2_need = out_q.rs2_need;
   assign out_rd_need = out_q.rd_need;
   assign out_class = out_q.cls;
   assign out_funct3 = out_q.funct3;
   assign out_is_w = out_q.is_w;
   assign out_is_muldiv = out_q.is_muldiv;
endmodule

// File: tb/tb_ysyx_22051468_decode_stage.sv
// tb_ysyx_22051468_decode_stage: drives an RV64+M and an RV32-without-M instance from shared
// inputs and compares both against a FIFO-of-decoded-bundles reference model.
module tb_ysyx_22051468_decode_stage;
   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [63:0] imm;
      logic        n1, n2, nd;
      logic [3:0]  cls;
      logic [2:0]  f3;
      logic        w, md;
   } exp_t;
   typedef struct {
      logic [31:0] inst;
      logic [3:0]  c64;
      logic [63:0] imm64;
      logic [3:0]  c32;
   } vec_t;

   logic clk = 1'b0, rst, flush, in_valid, out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc;
   always #5 clk = ~clk;

   logic a_ready, a_valid, a_n1, a_n2, a_nd, a_w, a_md;
   logic [31:0] a_inst;
   logic [63:0] a_pc, a_imm;
   logic [4:0] a_rs1, a_rs2, a_rd;
   logic [3:0] a_cls;
   logic [2:0] a_f3;
   logic b_ready, b_valid, b_n1, b_n2, b_nd, b_w, b_md;
   logic [31:0] b_inst, b_pc, b_imm;
   logic [4:0] b_rs1, b_rs2, b_rd;
   logic [3:0] b_cls;
   logic [2:0] b_f3;

   ysyx_22051468_decode_stage #(.WIDTH(64), .EN_M(1)) u_a (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ready),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_valid), .out_ready(out_ready),
      .out_inst(a_inst), .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
      .out_imm(a_imm), .out_rs1_need(a_n1), .out_rs2_need(a_n2), .out_rd_need(a_nd),
      .out_class(a_cls), .out_funct3(a_f3), .out_is_w(a_w), .out_is_muldiv(a_md));
   ysyx_22051468_decode_stage #(.WIDTH(32), .EN_M(0)) u_b (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ready),
      .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(b_valid), .out_ready(out_ready),
      .out_inst(b_inst), .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
      .out_imm(b_imm), .out_rs1_need(b_n1), .out_rs2_need(b_n2), .out_rd_need(b_nd),
      .out_class(b_cls), .out_funct3(b_f3), .out_is_w(b_w), .out_is_muldiv(b_md));

   wire exp_t a_act = {a_inst, a_pc, a_rs1, a_rs2, a_rd, a_imm, a_n1, a_n2, a_nd, a_cls, a_f3, a_w, a_md};
   wire exp_t b_act = {b_inst, 32'b0, b_pc, b_rs1, b_rs2, b_rd, 32'b0, b_imm, b_n1, b_n2, b_nd,
                       b_cls, b_f3, b_w, b_md};

   int n_vec = 0, n_bad = 0;

   // Reference decoder: immediates are rebuilt numerically (field value times scale, minus the
   // sign weight) and register-use flags come straight from the class lists.
   function automatic exp_t ref_dec(logic [31:0] i, logic [63:0] pc, bit rv64, bit has_m);
      exp_t e;
      logic [6:0] op, f7;
      logic [2:0] f3;
      longint imm;
      bit s, rok;
      op = i[6:0]; f7 = i[31:25]; f3 = i[14:12]; s = i[31]; imm = 0; e = '0;
      rok = f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 1 && has_m);
      case (op)
         7'h33: e.cls = rok ? 4'd0 : 4'd15;
         7'h3b: e.cls = (rok && rv64) ? 4'd0 : 4'd15;
         7'h13: begin
            e.cls = (!rv64 && i[25] && (f3 == 1 || f3 == 5)) ? 4'd15 : 4'd1;
            imm = longint'(i[31:20]) - (s ? 64'sd4096 : 64'sd0);
         end
         7'h1b: begin e.cls = rv64 ? 4'd1 : 4'd15; imm = longint'(i[31:20]) - (s ? 64'sd4096 : 64'sd0); end
         7'h03: begin e.cls = 2; imm = longint'(i[31:20]) - (s ? 64'sd4096 : 64'sd0); end
         7'h23: begin e.cls = 3; imm = longint'({i[31:25], i[11:7]}) - (s ? 64'sd4096 : 64'sd0); end
         7'h63: begin e.cls = 4; imm = longint'({i[31], i[7], i[30:25], i[11:8]}) * 2 - (s ? 64'sd8192 : 64'sd0); end
         7'h6f: begin e.cls = 5; imm = longint'({i[31], i[19:12], i[20], i[30:21]}) * 2 - (s ? 64'sd2097152 : 64'sd0); end
         7'h67: begin e.cls = 6; imm = longint'(i[31:20]) - (s ? 64'sd4096 : 64'sd0); end
         7'h37: begin e.cls = 7; imm = longint'(i[31:12]) * 4096 - (s ? 64'sh1_0000_0000 : 64'sd0); end
         7'h17: begin e.cls = 8; imm = longint'(i[31:12]) * 4096 - (s ? 64'sh1_0000_0000 : 64'sd0); end
         7'h73: e.cls = (i == 32'h0010_0073) ? 4'd9 : 4'd15;
         default: e.cls = 15;
      endcase
      e.inst = i;
      e.pc = rv64 ? pc : {32'b0, pc[31:0]};
      e.f3 = f3;
      if (e.cls != 15) begin
         e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
         e.imm = rv64 ? imm : (imm & 64'hffff_ffff);
         e.w = (op == 7'h3b || op == 7'h1b);
         e.md = (op == 7'h33 || op == 7'h3b) && f7 == 1;
      end
      e.n1 = e.cls inside {0, 1, 2, 3, 4, 6};
      e.n2 = e.cls inside {0, 3, 4};
      e.nd = e.cls inside {0, 1, 2, 5, 6, 7, 8};
      return e;
   endfunction

   exp_t qa[$], qb[$];
   bit da, db, fa, fb;
   exp_t ea, eb;
   always @(posedge clk) begin
      fa = in_valid && !rst && !da && qa.size() < 2;
      fb = in_valid && !rst && !db && qb.size() < 2;
      if (rst || flush) begin
         qa.delete(); qb.delete(); da = 0; db = 0;
      end else begin
         if (out_ready && qa.size() > 0) void'(qa.pop_front());
         if (out_ready && qb.size() > 0) void'(qb.pop_front());
         if (fa) begin ea = ref_dec(in_inst, in_pc, 1, 1); qa.push_back(ea); if (ea.cls inside {9, 15}) da = 1; end
         if (fb) begin eb = ref_dec(in_inst, in_pc, 0, 0); qb.push_back(eb); if (eb.cls inside {9, 15}) db = 1; end
      end
   end

   task automatic chk(string nm, exp_t act, exp_t exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_model();
      chk("a_in_ready", exp_t'(a_ready), exp_t'(!rst && !da && qa.size() < 2));
      chk("b_in_ready", exp_t'(b_ready), exp_t'(!rst && !db && qb.size() < 2));
      chk("a_out_valid", exp_t'(a_valid), exp_t'(qa.size() > 0));
      chk("b_out_valid", exp_t'(b_valid), exp_t'(qb.size() > 0));
      if (qa.size() > 0) chk("a_bundle", a_act, qa[0]);
      if (qb.size() > 0) chk("b_bundle", b_act, qb[0]);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_model();
   endtask

   vec_t tbl[20];
   logic [6:0] opcs[12];
   initial begin
      tbl[0]  = '{32'hfff00093, 4'd1,  64'hffff_ffff_ffff_ffff, 4'd1};
      tbl[1]  = '{32'h008000ef, 4'd5,  64'd8,                   4'd5};
      tbl[2]  = '{32'hfe000ee3, 4'd4,  64'hffff_ffff_ffff_fffc, 4'd4};
      tbl[3]  = '{32'h02208033, 4'd0,  64'd0,                   4'd15};
      tbl[4]  = '{32'h0020803b, 4'd0,  64'd0,                   4'd15};
      tbl[5]  = '{32'h00100073, 4'd9,  64'd0,                   4'd9};
      tbl[6]  = '{32'h00000073, 4'd15, 64'd0,                   4'd15};
      tbl[7]  = '{32'h0000007f, 4'd15, 64'd0,                   4'd15};
      tbl[8]  = '{32'h40208033, 4'd0,  64'd0,                   4'd0};
      tbl[9]  = '{32'h40209033, 4'd15, 64'd0,                   4'd15};
      tbl[10] = '{32'h4020d013, 4'd1,  64'h402,                 4'd1};
      tbl[11] = '{32'h02009013, 4'd1,  64'h20,                  4'd15};
      tbl[12] = '{32'h123450b7, 4'd7,  64'h1234_5000,           4'd7};
      tbl[13] = '{32'h800000b7, 4'd7,  64'hffff_ffff_8000_0000, 4'd7};
      tbl[14] = '{32'h00112423, 4'd3,  64'd8,                   4'd3};
      tbl[15] = '{32'h00813083, 4'd2,  64'd8,                   4'd2};
      tbl[16] = '{32'h00000097, 4'd8,  64'd0,                   4'd8};
      tbl[17] = '{32'h000080e7, 4'd6,  64'd0,                   4'd6};
      tbl[18] = '{32'h0220c0bb, 4'd0,  64'd0,                   4'd15};
      tbl[19] = '{32'h0010051b, 4'd1,  64'd1,                   4'd15};
      opcs = '{7'h33, 7'h3b, 7'h13, 7'h1b, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73};

      rst = 1; flush = 0; in_valid = 0; out_ready = 1; in_inst = 0; in_pc = 0;
      step(); step();
      chk("reset_payload_a", a_act, '0);
      chk("reset_payload_b", b_act, '0);
      rst = 0;
      step();

      foreach (tbl[k]) begin
         flush = 1; in_valid = 0; step();
         flush = 0; in_inst = tbl[k].inst; in_pc = {$urandom, $urandom}; in_valid = 1; out_ready = 1;
         step();
         in_valid = 0;
         chk("tbl_valid", exp_t'(a_valid), exp_t'(1));
         chk("tbl_class64", exp_t'(a_cls), exp_t'(tbl[k].c64));
         chk("tbl_imm64", exp_t'(a_imm), exp_t'(tbl[k].imm64));
         chk("tbl_class32", exp_t'(b_cls), exp_t'(tbl[k].c32));
      end

      // Stalled output: two beats buffer, third waits, order preserved on release.
      flush = 1; step(); flush = 0;
      out_ready = 0; in_inst = 32'hfff00093; in_valid = 1;
      in_pc = 64'h100; step();
      in_pc = 64'h104; step();
      chk("stall_ready_drop", exp_t'(a_ready), exp_t'(0));
      in_pc = 64'h108; step(); step();
      out_ready = 1; step();
      chk("stall_order2", exp_t'(a_pc), exp_t'(64'h104));
      step();
      in_valid = 0;
      chk("stall_order3", exp_t'(a_pc), exp_t'(64'h108));
      step();

      // EBREAK serializes until flush; the beat shown in the flush cycle is dropped.
      flush = 1; step(); flush = 0;
      in_inst = 32'h00100073; in_valid = 1; step();
      in_inst = 32'h002080b3;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("drain_hold", exp_t'(a_ready), exp_t'(0));
      end
      flush = 1; step(); flush = 0;
      chk("flush_valid", exp_t'(a_valid), exp_t'(0));
      chk("flush_ready", exp_t'(a_ready), exp_t'(1));
      step();
      in_valid = 0;
      chk("post_flush_add", exp_t'(a_inst), exp_t'(32'h002080b3));

      // Both entries full then flush.
      flush = 1; step(); flush = 0;
      out_ready = 0; in_inst = 32'h00813083; in_valid = 1; step(); step();
      in_valid = 0; flush = 1; step(); flush = 0;
      chk("full_flush_valid", exp_t'(a_valid), exp_t'(0));
      out_ready = 1; step();
      chk("full_flush_empty", exp_t'(a_valid), exp_t'(0));

      // Reset together with flush in the middle of a stall.
      out_ready = 0; in_inst = 32'h123450b7; in_valid = 1; step(); step();
      in_valid = 0; rst = 1; flush = 1; step();
      chk("rst_mid_a", a_act, '0);
      chk("rst_mid_b", b_act, '0);
      chk("rst_mid_valid", exp_t'({a_valid, b_valid, a_ready, b_ready}), '0);
      rst = 0; flush = 0; step();

      for (int c = 0; c < 1500; c++) begin
         case ($urandom_range(0, 3))
            0: in_inst = tbl[$urandom_range(0, 19)].inst;
            1: in_inst = $urandom;
            default: in_inst = {$urandom_range(0, 1) ? 7'h00 : 7'($urandom), 18'($urandom), opcs[$urandom_range(0, 11)]};
         endcase
         in_pc = {$urandom, $urandom};
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         flush = ($urandom_range(0, 39) == 0) || ((da || db) && $urandom_range(0, 4) == 0);
         rst = $urandom_range(0, 199) == 0;
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
